// File: rtl/icache_tag_cam_if.sv
// icache_tag_cam_if: request/response bundle between the fetch/coherence logic and the tag CAM.
// Parameters:
//   TAG_W - tag width
//   DP    - number of entries
// Request signals, driven by the master:
//   flush            - invalidate everything
//   lkp_req/lkp_tag  - lookup strobe and tag
//   alloc_wr/alloc_tag - allocate or refresh strobe and tag
//   inv_req/inv_tag  - invalidate-by-tag strobe and tag
// Response signals, driven by the slave:
//   lkp_vld/lkp_hit/lkp_idx/lkp_nxt_hit - registered lookup response
//   vict_idx/vict_valid/vict_tag        - combinational victim for the next allocation
//   valid_cnt/full/empty                - occupancy
interface icache_tag_cam_if #(
    parameter int TAG_W = 20,
    parameter int DP    = 8
);
    localparam int AW = $clog2(DP);

    logic             flush;
    logic             lkp_req;
    logic [TAG_W-1:0] lkp_tag;
    logic             lkp_vld;
    logic             lkp_hit;
    logic [AW-1:0]    lkp_idx;
    logic             lkp_nxt_hit;
    logic             alloc_wr;
    logic [TAG_W-1:0] alloc_tag;
    logic [AW-1:0]    vict_idx;
    logic             vict_valid;
    logic [TAG_W-1:0] vict_tag;
    logic             inv_req;
    logic [TAG_W-1:0] inv_tag;
    logic [AW:0]      valid_cnt;
    logic             full;
    logic             empty;

    modport master (
        output flush, lkp_req, lkp_tag, alloc_wr, alloc_tag, inv_req, inv_tag,
        input  lkp_vld, lkp_hit, lkp_idx, lkp_nxt_hit, vict_idx, vict_valid, vict_tag,
               valid_cnt, full, empty
    );

    modport slave (
        input  flush, lkp_req, lkp_tag, alloc_wr, alloc_tag, inv_req, inv_tag,
        output lkp_vld, lkp_hit, lkp_idx, lkp_nxt_hit, vict_idx, vict_valid, vict_tag,
               valid_cnt, full, empty
    );
endinterface

// File: rtl/icache_tag_cam.sv
// icache_tag_cam: fully-associative icache tag store with FIFO or true-LRU replacement.
// Parameters:
//   TAG_W - tag width
//   DP    - number of entries, a power of 2
//   REPL  - replacement policy: 0 = FIFO round-robin, 1 = true LRU
// Ports:
//   clk     - clock
//   reset_n - asynchronous, active-low reset
//   bus     - icache_tag_cam_if.slave, carrying:
//             lookup (registered, 1-cycle latency, includes a next-line hit),
//             allocate/refresh with duplicate suppression,
//             invalidate-by-tag,
//             flush,
//             victim preview,
//             occupancy.
module icache_tag_cam #(
    parameter int TAG_W = 20,
    parameter int DP    = 8,
    parameter int REPL  = 0
) (
    input logic             clk,
    input logic             reset_n,
    icache_tag_cam_if.slave bus
);
    localparam int AW = $clog2(DP);

    logic [DP-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [DP];
    logic [TAG_W-1:0] tag_d [DP];
    logic [AW-1:0]    age_q [DP];
    logic [AW-1:0]    age_d [DP];
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             lkp_vld_q, lkp_vld_d;
    logic             lkp_hit_q, lkp_hit_d;
    logic [AW-1:0]    lkp_idx_q, lkp_idx_d;
    logic             lkp_nxt_q, lkp_nxt_d;

    logic [TAG_W-1:0] nxt_tag;
    logic             l_hit, l_nxt, a_hit, any_free, full_w, t_en;
    logic [AW-1:0]    l_idx, a_idx, free_idx, old_idx, vict, tgt, t_idx;
    logic [AW:0]      cnt;

    // Match logic against pre-edge state; the later index overrides, so the highest hit wins.
    always_comb begin
        nxt_tag  = bus.lkp_tag + TAG_W'(1);
        l_hit    = 1'b0;
        l_nxt    = 1'b0;
        l_idx    = '0;
        a_hit    = 1'b0;
        a_idx    = '0;
        old_idx  = '0;
        any_free = 1'b0;
        free_idx = '0;
        cnt      = '0;
        for (int i = 0; i < DP; i++) begin
            if (valid_q[i] && tag_q[i] == bus.lkp_tag) begin
                l_hit = 1'b1;
                l_idx = AW'(i);
            end
            if (valid_q[i] && tag_q[i] == nxt_tag) l_nxt = 1'b1;
            if (valid_q[i] && tag_q[i] == bus.alloc_tag) begin
                a_hit = 1'b1;
                a_idx = AW'(i);
            end
            if (age_q[i] == AW'(DP - 1)) old_idx = AW'(i);
            cnt = cnt + (AW+1)'(valid_q[i]);
        end
        // Descending scan leaves the lowest invalid index.
        for (int i = DP - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_idx = AW'(i);
            end
        end
        vict   = any_free ? free_idx : (REPL != 0 ? old_idx : ptr_q);
        full_w = cnt == (AW+1)'(DP);
    end

    // Next state; flush overrides everything and discards same-cycle requests.
    always_comb begin
        tgt   = a_hit ? a_idx : vict;
        // An allocate touch takes precedence over a lookup-hit touch.
        t_en  = bus.alloc_wr || (bus.lkp_req && l_hit);
        t_idx = bus.alloc_wr ? tgt : l_idx;
        ptr_d = (bus.alloc_wr && !a_hit && full_w) ? ptr_q + AW'(1) : ptr_q;
        for (int i = 0; i < DP; i++) begin
            valid_d[i] = valid_q[i];
            tag_d[i]   = tag_q[i];
            age_d[i]   = age_q[i];
            if (bus.inv_req && valid_q[i] && tag_q[i] == bus.inv_tag) valid_d[i] = 1'b0;
            // Applied after invalidate so an allocate to the same entry keeps it valid.
            if (bus.alloc_wr && tgt == AW'(i)) begin
                valid_d[i] = 1'b1;
                if (!a_hit) tag_d[i] = bus.alloc_tag;
            end
            if (REPL != 0 && t_en)
                age_d[i] = (AW'(i) == t_idx) ? '0 :
                           (age_q[i] < age_q[t_idx]) ? age_q[i] + AW'(1) : age_q[i];
            if (bus.flush) begin
                valid_d[i] = 1'b0;
                tag_d[i]   = '0;
                age_d[i]   = AW'(i);
            end
        end
        if (bus.flush) ptr_d = '0;
        lkp_vld_d = bus.lkp_req && !bus.flush;
        lkp_hit_d = lkp_vld_d && l_hit;
        lkp_idx_d = lkp_hit_d ? l_idx : '0;
        lkp_nxt_d = lkp_vld_d && l_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= '0;
            ptr_q     <= '0;
            lkp_vld_q <= 1'b0;
            lkp_hit_q <= 1'b0;
            lkp_idx_q <= '0;
            lkp_nxt_q <= 1'b0;
            for (int i = 0; i < DP; i++) begin
                tag_q[i] <= '0;
                age_q[i] <= AW'(i);
            end
        end else begin
            valid_q   <= valid_d;
            ptr_q     <= ptr_d;
            lkp_vld_q <= lkp_vld_d;
            lkp_hit_q <= lkp_hit_d;
            lkp_idx_q <= lkp_idx_d;
            lkp_nxt_q <= lkp_nxt_d;
            tag_q     <= tag_d;
            age_q     <= age_d;
        end
    end

    assign bus.lkp_vld     = lkp_vld_q;
    assign bus.lkp_hit     = lkp_hit_q;
    assign bus.lkp_idx     = lkp_idx_q;
    assign bus.lkp_nxt_hit = lkp_nxt_q;
    assign bus.vict_idx    = vict;
    assign bus.vict_valid  = valid_q[vict];
    assign bus.vict_tag    = tag_q[vict];
    assign bus.valid_cnt   = cnt;
    assign bus.full        = full_w;
    assign bus.empty       = cnt == '0;
endmodule

// File: tb/tb_icache_tag_cam.sv
// tb_icache_tag_cam: directed self-checking bench driving a FIFO (u0) and an LRU (u1) instance in lockstep.
module tb_icache_tag_cam;
    localparam int TAG_W = 20;
    localparam int DP    = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0, lkp_req = 1'b0, alloc_wr = 1'b0, inv_req = 1'b0;
    logic [TAG_W-1:0] lkp_tag = '0, alloc_tag = '0, inv_tag = '0;
    int               tests = 0, fails = 0;

    always #5 clk = ~clk;

    icache_tag_cam_if #(.TAG_W(TAG_W), .DP(DP)) f0 ();
    icache_tag_cam_if #(.TAG_W(TAG_W), .DP(DP)) f1 ();

    assign f0.flush = flush;         assign f1.flush = flush;
    assign f0.lkp_req = lkp_req;     assign f1.lkp_req = lkp_req;
    assign f0.lkp_tag = lkp_tag;     assign f1.lkp_tag = lkp_tag;
    assign f0.alloc_wr = alloc_wr;   assign f1.alloc_wr = alloc_wr;
    assign f0.alloc_tag = alloc_tag; assign f1.alloc_tag = alloc_tag;
    assign f0.inv_req = inv_req;     assign f1.inv_req = inv_req;
    assign f0.inv_tag = inv_tag;     assign f1.inv_tag = inv_tag;

    icache_tag_cam #(.TAG_W(TAG_W), .DP(DP), .REPL(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(f0.slave));
    icache_tag_cam #(.TAG_W(TAG_W), .DP(DP), .REPL(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(f1.slave));

    // {vld, hit, idx, nxt}, {valid, idx, tag}, {full, empty, cnt}
    wire [5:0]  rsp0 = {f0.lkp_vld, f0.lkp_hit, f0.lkp_idx, f0.lkp_nxt_hit};
    wire [5:0]  rsp1 = {f1.lkp_vld, f1.lkp_hit, f1.lkp_idx, f1.lkp_nxt_hit};
    wire [23:0] vic0 = {f0.vict_valid, f0.vict_idx, f0.vict_tag};
    wire [23:0] vic1 = {f1.vict_valid, f1.vict_idx, f1.vict_tag};
    wire [5:0]  st0  = {f0.full, f0.empty, f0.valid_cnt};
    wire [5:0]  st1  = {f1.full, f1.empty, f1.valid_cnt};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [TAG_W-1:0] t);
        lkp_req = 1'b1;
        lkp_tag = t;
        step();
        lkp_req = 1'b0;
    endtask

    task automatic do_alloc(input logic [TAG_W-1:0] t);
        alloc_wr  = 1'b1;
        alloc_tag = t;
        step();
        alloc_wr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (st0 !== {1'b0, 1'b1, 4'd0}) begin fails++; $display("FAIL rst_async_st0: got %b want %b", st0, {1'b0, 1'b1, 4'd0}); end
        reset_n = 1'b1;
        step();
        tests++; if (st1 !== {1'b0, 1'b1, 4'd0}) begin fails++; $display("FAIL rst_st1: got %b want %b", st1, {1'b0, 1'b1, 4'd0}); end
        tests++; if (rsp0 !== 6'b0) begin fails++; $display("FAIL rst_rsp0: got %b want %b", rsp0, 6'b0); end
        tests++; if (vic0 !== 24'h0) begin fails++; $display("FAIL rst_vic0: got %h want %h", vic0, 24'h0); end
        tests++; if (vic1 !== 24'h0) begin fails++; $display("FAIL rst_vic1: got %h want %h", vic1, 24'h0); end
        do_lookup(20'h00010);
        tests++; if (rsp0 !== {1'b1, 1'b0, 3'd0, 1'b0}) begin fails++; $display("FAIL rst_lkp0: got %b want %b", rsp0, {1'b1, 1'b0, 3'd0, 1'b0}); end
        tests++; if (rsp1 !== {1'b1, 1'b0, 3'd0, 1'b0}) begin fails++; $display("FAIL rst_lkp1: got %b want %b", rsp1, {1'b1, 1'b0, 3'd0, 1'b0}); end
        step();
        tests++; if (f0.lkp_vld !== 1'b0) begin fails++; $display("FAIL rst_vld_drop: got %b want 0", f0.lkp_vld); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < DP; k++) begin
            tests++; if (f0.vict_idx !== AW'(k)) begin fails++; $display("FAIL fill_vict0_%0d: got %0d want %0d", k, f0.vict_idx, k); end
            tests++; if (f1.vict_idx !== AW'(k)) begin fails++; $display("FAIL fill_vict1_%0d: got %0d want %0d", k, f1.vict_idx, k); end
            do_alloc(20'h00100 + TAG_W'(k));
        end
        tests++; if (st0 !== {1'b1, 1'b0, 4'd8}) begin fails++; $display("FAIL fill_st0: got %b want %b", st0, {1'b1, 1'b0, 4'd8}); end
        tests++; if (st1 !== {1'b1, 1'b0, 4'd8}) begin fails++; $display("FAIL fill_st1: got %b want %b", st1, {1'b1, 1'b0, 4'd8}); end
        do_lookup(20'h00103);
        tests++; if (rsp0 !== {1'b1, 1'b1, 3'd3, 1'b1}) begin fails++; $display("FAIL lkp103_0: got %b want %b", rsp0, {1'b1, 1'b1, 3'd3, 1'b1}); end
        tests++; if (rsp1 !== {1'b1, 1'b1, 3'd3, 1'b1}) begin fails++; $display("FAIL lkp103_1: got %b want %b", rsp1, {1'b1, 1'b1, 3'd3, 1'b1}); end
        do_lookup(20'h00107);
        tests++; if (rsp0 !== {1'b1, 1'b1, 3'd7, 1'b0}) begin fails++; $display("FAIL lkp107_0: got %b want %b", rsp0, {1'b1, 1'b1, 3'd7, 1'b0}); end
        tests++; if (rsp1 !== {1'b1, 1'b1, 3'd7, 1'b0}) begin fails++; $display("FAIL lkp107_1: got %b want %b", rsp1, {1'b1, 1'b1, 3'd7, 1'b0}); end
    endtask

    task automatic test_lru_touch();
        do_lookup(20'h00100);
        tests++; if (rsp1 !== {1'b1, 1'b1, 3'd0, 1'b1}) begin fails++; $display("FAIL lkp100_1: got %b want %b", rsp1, {1'b1, 1'b1, 3'd0, 1'b1}); end
        do_lookup(20'h00101);
        tests++; if (rsp1 !== {1'b1, 1'b1, 3'd1, 1'b1}) begin fails++; $display("FAIL lkp101_1: got %b want %b", rsp1, {1'b1, 1'b1, 3'd1, 1'b1}); end
        tests++; if (vic0 !== {1'b1, 3'd0, 20'h00100}) begin fails++; $display("FAIL fifo_vic_pre: got %h want %h", vic0, {1'b1, 3'd0, 20'h00100}); end
        tests++; if (vic1 !== {1'b1, 3'd2, 20'h00102}) begin fails++; $display("FAIL lru_vic_pre: got %h want %h", vic1, {1'b1, 3'd2, 20'h00102}); end
    endtask

    task automatic test_replace();
        do_alloc(20'h00200);
        tests++; if (vic0 !== {1'b1, 3'd1, 20'h00101}) begin fails++; $display("FAIL fifo_vic_200: got %h want %h", vic0, {1'b1, 3'd1, 20'h00101}); end
        tests++; if (vic1 !== {1'b1, 3'd4, 20'h00104}) begin fails++; $display("FAIL lru_vic_200: got %h want %h", vic1, {1'b1, 3'd4, 20'h00104}); end
        do_alloc(20'h00201);
        tests++; if (vic0 !== {1'b1, 3'd2, 20'h00102}) begin fails++; $display("FAIL fifo_vic_201: got %h want %h", vic0, {1'b1, 3'd2, 20'h00102}); end
        tests++; if (vic1 !== {1'b1, 3'd5, 20'h00105}) begin fails++; $display("FAIL lru_vic_201: got %h want %h", vic1, {1'b1, 3'd5, 20'h00105}); end
        do_alloc(20'h00103);
        tests++; if (vic0 !== {1'b1, 3'd2, 20'h00102}) begin fails++; $display("FAIL fifo_refresh: got %h want %h", vic0, {1'b1, 3'd2, 20'h00102}); end
        tests++; if (st0 !== {1'b1, 1'b0, 4'd8}) begin fails++; $display("FAIL refresh_st0: got %b want %b", st0, {1'b1, 1'b0, 4'd8}); end
        tests++; if (vic1 !== {1'b1, 3'd5, 20'h00105}) begin fails++; $display("FAIL lru_refresh: got %h want %h", vic1, {1'b1, 3'd5, 20'h00105}); end
    endtask

    task automatic test_inv_alloc();
        inv_req = 1'b1;
        inv_tag = 20'h00105;
        do_alloc(20'h00400);
        inv_req = 1'b0;
        tests++; if (st0 !== {1'b0, 1'b0, 4'd7}) begin fails++; $display("FAIL inv_alloc_st0: got %b want %b", st0, {1'b0, 1'b0, 4'd7}); end
        tests++; if ({f0.vict_valid, f0.vict_idx} !== {1'b0, 3'd5}) begin fails++; $display("FAIL inv_alloc_vic0: got %b want %b", {f0.vict_valid, f0.vict_idx}, {1'b0, 3'd5}); end
        tests++; if (st1 !== {1'b1, 1'b0, 4'd8}) begin fails++; $display("FAIL inv_same_st1: got %b want %b", st1, {1'b1, 1'b0, 4'd8}); end
        tests++; if (vic1 !== {1'b1, 3'd6, 20'h00106}) begin fails++; $display("FAIL inv_same_vic1: got %h want %h", vic1, {1'b1, 3'd6, 20'h00106}); end
        do_lookup(20'h00105);
        tests++; if (rsp0 !== {1'b1, 1'b0, 3'd0, 1'b1}) begin fails++; $display("FAIL lkp105_0: got %b want %b", rsp0, {1'b1, 1'b0, 3'd0, 1'b1}); end
        tests++; if (rsp1 !== {1'b1, 1'b0, 3'd0, 1'b1}) begin fails++; $display("FAIL lkp105_1: got %b want %b", rsp1, {1'b1, 1'b0, 3'd0, 1'b1}); end
        do_lookup(20'h00400);
        tests++; if (rsp0 !== {1'b1, 1'b1, 3'd2, 1'b0}) begin fails++; $display("FAIL lkp400_0: got %b want %b", rsp0, {1'b1, 1'b1, 3'd2, 1'b0}); end
        tests++; if (rsp1 !== {1'b1, 1'b1, 3'd5, 1'b0}) begin fails++; $display("FAIL lkp400_1: got %b want %b", rsp1, {1'b1, 1'b1, 3'd5, 1'b0}); end
        do_alloc(20'h00401);
        tests++; if (st0 !== {1'b1, 1'b0, 4'd8}) begin fails++; $display("FAIL alloc401_st0: got %b want %b", st0, {1'b1, 1'b0, 4'd8}); end
        tests++; if (vic0 !== {1'b1, 3'd3, 20'h00103}) begin fails++; $display("FAIL alloc401_vic0: got %h want %h", vic0, {1'b1, 3'd3, 20'h00103}); end
        tests++; if (vic1 !== {1'b1, 3'd7, 20'h00107}) begin fails++; $display("FAIL alloc401_vic1: got %h want %h", vic1, {1'b1, 3'd7, 20'h00107}); end
        inv_req = 1'b1;
        inv_tag = 20'h00999;
        step();
        tests++; if (st0 !== {1'b1, 1'b0, 4'd8}) begin fails++; $display("FAIL inv_miss_st0: got %b want %b", st0, {1'b1, 1'b0, 4'd8}); end
        inv_tag = 20'h00401;
        step();
        inv_req = 1'b0;
        tests++; if ({f0.valid_cnt, f0.vict_valid, f0.vict_idx} !== {4'd7, 1'b0, 3'd5}) begin fails++; $display("FAIL inv401_0: got %b want %b", {f0.valid_cnt, f0.vict_valid, f0.vict_idx}, {4'd7, 1'b0, 3'd5}); end
        tests++; if ({f1.valid_cnt, f1.vict_valid, f1.vict_idx} !== {4'd7, 1'b0, 3'd6}) begin fails++; $display("FAIL inv401_1: got %b want %b", {f1.valid_cnt, f1.vict_valid, f1.vict_idx}, {4'd7, 1'b0, 3'd6}); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        lkp_req = 1'b1;
        lkp_tag = 20'h00400;
        inv_req = 1'b1;
        inv_tag = 20'h00103;
        do_alloc(20'h00555);
        flush = 1'b0;
        inv_req = 1'b0;
        tests++; if (f0.lkp_vld !== 1'b0) begin fails++; $display("FAIL flush_vld0: got %b want 0", f0.lkp_vld); end
        tests++; if (st0 !== {1'b0, 1'b1, 4'd0}) begin fails++; $display("FAIL flush_st0: got %b want %b", st0, {1'b0, 1'b1, 4'd0}); end
        tests++; if (st1 !== {1'b0, 1'b1, 4'd0}) begin fails++; $display("FAIL flush_st1: got %b want %b", st1, {1'b0, 1'b1, 4'd0}); end
        tests++; if (vic1 !== 24'h0) begin fails++; $display("FAIL flush_vic1: got %h want %h", vic1, 24'h0); end
        do_lookup(20'h00555);
        tests++; if (rsp0 !== {1'b1, 1'b0, 3'd0, 1'b0}) begin fails++; $display("FAIL flush_lkp555: got %b want %b", rsp0, {1'b1, 1'b0, 3'd0, 1'b0}); end
    endtask

    task automatic test_wrap();
        lkp_req = 1'b1;
        lkp_tag = 20'hFFFFF;
        do_alloc(20'hFFFFF);
        tests++; if (rsp0 !== {1'b1, 1'b0, 3'd0, 1'b0}) begin fails++; $display("FAIL same_cyc_lkp0: got %b want %b", rsp0, {1'b1, 1'b0, 3'd0, 1'b0}); end
        do_lookup(20'hFFFFE);
        tests++; if (rsp0 !== {1'b1, 1'b0, 3'd0, 1'b1}) begin fails++; $display("FAIL lkpFFFFE_0: got %b want %b", rsp0, {1'b1, 1'b0, 3'd0, 1'b1}); end
        tests++; if (rsp1 !== {1'b1, 1'b0, 3'd0, 1'b1}) begin fails++; $display("FAIL lkpFFFFE_1: got %b want %b", rsp1, {1'b1, 1'b0, 3'd0, 1'b1}); end
        do_lookup(20'hFFFFF);
        tests++; if (rsp0 !== {1'b1, 1'b1, 3'd0, 1'b0}) begin fails++; $display("FAIL lkpFFFFF_inv0: got %b want %b", rsp0, {1'b1, 1'b1, 3'd0, 1'b0}); end
        do_alloc(20'h00000);
        do_lookup(20'hFFFFF);
        tests++; if (rsp0 !== {1'b1, 1'b1, 3'd0, 1'b1}) begin fails++; $display("FAIL lkpFFFFF_wrap0: got %b want %b", rsp0, {1'b1, 1'b1, 3'd0, 1'b1}); end
        tests++; if (rsp1 !== {1'b1, 1'b1, 3'd0, 1'b1}) begin fails++; $display("FAIL lkpFFFFF_wrap1: got %b want %b", rsp1, {1'b1, 1'b1, 3'd0, 1'b1}); end
    endtask

    task automatic test_back_to_back();
        lkp_req = 1'b1;
        lkp_tag = 20'hFFFFE;
        step();
        tests++; if (rsp0 !== {1'b1, 1'b0, 3'd0, 1'b1}) begin fails++; $display("FAIL b2b_first: got %b want %b", rsp0, {1'b1, 1'b0, 3'd0, 1'b1}); end
        lkp_tag = 20'h00000;
        step();
        tests++; if (rsp0 !== {1'b1, 1'b1, 3'd1, 1'b0}) begin fails++; $display("FAIL b2b_second: got %b want %b", rsp0, {1'b1, 1'b1, 3'd1, 1'b0}); end
        lkp_req = 1'b0;
        step();
        tests++; if (rsp1 !== 6'b0) begin fails++; $display("FAIL b2b_idle: got %b want %b", rsp1, 6'b0); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_lru_touch();
        test_replace();
        test_inv_alloc();
        test_flush();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
